// File: rtl/w0rm_mem_responder.sv
// Word-addressed memory responder: requests enter a fixed-latency pipeline, responses drain through an in-order buffer.
// Latency: a response is visible LATENCY edges after its accept edge when the buffer is empty; otherwise it waits for the head.
// Backpressure: credit counting stops accepting once FIFO_DEPTH responses are outstanding; a stalled response holds its value.
module w0rm_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid_i,
    input  logic                  req_read_i,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_write_o,
    output logic                  rsp_error_o
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic                  write;
        logic                  error;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [CNT_W-1:0]      credit_q;
    logic                  accept;
    logic                  pop;
    logic [63:0]           word_idx;
    logic                  req_err;
    logic [MEM_AW-1:0]     mem_idx;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    rsp_t                  req_rsp;
    logic [LATENCY-1:0]    pipe_vld_q;
    rsp_t                  pipe_dat_q [LATENCY];
    logic                  head_vld;
    rsp_t                  head_dat;

    assign req_ready_o = reset_n && (credit_q < CREDIT_MAX);
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = head_vld && rsp_ready_i;

    always_comb begin
        word_idx     = 64'(req_addr_i[ADDR_WIDTH-1:2]);
        mem_idx      = word_idx[MEM_AW-1:0];
        req_err      = (req_addr_i[1:0] != 2'b00) || (word_idx >= 64'(MEM_DEPTH))
                       || (req_read_i == req_write_i);
        req_rsp      = '0;
        req_rsp.write = req_write_i;
        req_rsp.error = req_err;
        // A legal read is exactly one with read set, write clear and a good address.
        if (req_read_i && !req_err) begin
            req_rsp.data = mem_q[mem_idx];
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && req_write_i && !req_err) begin
            mem_q[mem_idx] <= req_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_dat_q[0] <= req_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
        end
    end

    // Credits cover both pipeline stages and buffer slots, so the buffer can never overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_q <= '0;
        end else if (accept && !pop) begin
            credit_q <= credit_q + 1'b1;
        end else if (!accept && pop) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    w0rm_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (pipe_vld_q[LATENCY-1]),
        .push_dat (pipe_dat_q[LATENCY-1]),
        .pop_rdy  (rsp_ready_i),
        .pop_vld  (head_vld),
        .pop_dat  (head_dat)
    );

    assign rsp_valid_o = head_vld;
    assign rsp_data_o  = head_vld ? head_dat.data  : '0;
    assign rsp_write_o = head_vld ? head_dat.write : 1'b0;
    assign rsp_error_o = head_vld ? head_dat.error : 1'b0;

endmodule

// Generic synchronous FIFO with registered storage and modulo-DEPTH pointers.
// Latency: a push is visible at the head from the edge that writes it.
// Backpressure: head holds until pop_rdy; a push into a full FIFO is dropped and flagged.
module w0rm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == FULL_CNT);
    assign pop_vld = (count_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    push_into_full: assert property (@(posedge clk) disable iff (!reset_n) !(push_vld && full));

endmodule

// File: tb/tb_w0rm_mem_responder.sv
// Randomized and directed bench for w0rm_mem_responder against a queue-based response model.
module tb_w0rm_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int MEM_D = 16;
    localparam int LAT   = 2;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_read_i = 1'b0;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_data_i = '0;
    logic          req_ready_o;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_write_o;
    logic          rsp_error_o;

    w0rm_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (MEM_D),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_read_i  (req_read_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_write_o (rsp_write_o),
        .rsp_error_o (rsp_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          wr;
        logic          err;
        int            due;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          wr;
        logic          err;
        int            cyc;
    } obs_t;

    exp_t          mq[$];
    obs_t          log_q[$];
    logic [DW-1:0] mdl_mem [MEM_D];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] f(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Model: every accepted request is queued with the edge at which it may first show.
    always @(negedge clk) begin
        exp_t        e;
        obs_t        o;
        logic        ev;
        logic        bad;
        logic [31:0] idx;
        int          sz;
        if (!reset_n) begin
            check("rst_req_ready", req_ready_o, 0);
            check("rst_rsp_valid", rsp_valid_o, 0);
            check("rst_rsp_data", rsp_data_o, 0);
            check("rst_rsp_write", rsp_write_o, 0);
            check("rst_rsp_error", rsp_error_o, 0);
            mq.delete();
        end else begin
            sz = mq.size();
            ev = (sz > 0) && (mq[0].due <= cyc);
            check("req_ready", req_ready_o, sz < FD);
            check("rsp_valid", rsp_valid_o, ev);
            if (ev && rsp_valid_o) begin
                check("rsp_data", rsp_data_o, mq[0].data);
                check("rsp_write", rsp_write_o, mq[0].wr);
                check("rsp_error", rsp_error_o, mq[0].err);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                o.data = rsp_data_o;
                o.wr   = rsp_write_o;
                o.err  = rsp_error_o;
                o.cyc  = cyc;
                log_q.push_back(o);
            end
            if (ev && rsp_ready_i) void'(mq.pop_front());
            if (req_valid_i && sz < FD) begin
                idx   = {16'b0, req_addr_i} >> 2;
                bad   = (req_addr_i[1:0] != 2'b00) || (idx >= MEM_D) || (req_read_i == req_write_i);
                e.wr  = req_write_i;
                e.err = bad;
                e.data = (!bad && req_read_i) ? mdl_mem[idx] : '0;
                e.due = cyc + 1 + LAT;
                if (!bad && req_write_i) mdl_mem[idx] = req_data_i;
                mq.push_back(e);
            end
        end
    end

    task automatic send(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int acc, output int stalls);
        stalls      = 0;
        req_valid_i = 1'b1;
        req_read_i  = rd;
        req_write_i = wr;
        req_addr_i  = a;
        req_data_i  = d;
        while (!req_ready_o && stalls < 200) begin
            @(posedge clk); #1;
            stalls++;
        end
        acc = cyc + 1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        if (stalls >= 200) check("send_timeout", stalls, 0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        while ((mq.size() != 0 || rsp_valid_o) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) check("drain_timeout", g, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, st, tot;
        logic [DW-1:0] keep;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_low", req_ready_o, 0);
        reset_n = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", req_ready_o, 1);

        for (int i = 0; i < MEM_D; i++) send(1'b0, 1'b1, AW'(i * 4), f(i), a0, st);
        drain();

        // Write then read the same word on the next cycle.
        log_q.delete();
        send(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, a0, st);
        send(1'b1, 1'b0, 16'h0010, 32'h0, a1, st);
        drain();
        check("wr_rd_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("wr_ack_write", log_q[0].wr, 1);
            check("wr_ack_error", log_q[0].err, 0);
            check("wr_ack_data", log_q[0].data, 0);
            check("wr_ack_cycle", log_q[0].cyc, a0 + LAT);
            check("rd_data", log_q[1].data, 32'hDEADBEEF);
            check("rd_write", log_q[1].wr, 0);
            check("rd_cycle", log_q[1].cyc, a0 + LAT + 1);
        end

        // Back-to-back reads come out on consecutive cycles, in order.
        log_q.delete();
        send(1'b1, 1'b0, 16'h0000, 32'h0, a0, st);
        send(1'b1, 1'b0, 16'h0004, 32'h0, a1, st);
        send(1'b1, 1'b0, 16'h0008, 32'h0, a1, st);
        drain();
        check("b2b_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("b2b_data", log_q[i].data, f(i));
                check("b2b_cycle", log_q[i].cyc, a0 + LAT + i);
            end
        end

        // Stalled consumer: only FD requests get in until responses drain.
        log_q.delete();
        rsp_ready_i = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int acc_l, st_l;
                    send(1'b1, 1'b0, AW'(32 + 4 * i), 32'h0, acc_l, st_l);
                    n_acc++;
                end
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check("stall_accepts", n_acc, 4);
                check("stall_ready_low", req_ready_o, 0);
                check("stall_head_data", rsp_data_o, f(8));
                rsp_ready_i = 1'b1;
            end
        join
        drain();
        check("stall_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("stall_order", log_q[i].data, f(8 + i));
        end

        // Illegal requests: misaligned, out of range, read==write.
        log_q.delete();
        send(1'b1, 1'b0, 16'h0002, 32'h0, a0, st);
        send(1'b1, 1'b0, AW'(4 * MEM_D), 32'h0, a0, st);
        send(1'b1, 1'b1, 16'h0000, 32'h12345678, a0, st);
        send(1'b1, 1'b0, 16'h0000, 32'h0, a0, st);
        drain();
        check("err_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                check("err_flag", log_q[i].err, 1);
                check("err_data", log_q[i].data, 0);
            end
            check("err_mem_kept", log_q[3].data, f(0));
            check("err_then_ok", log_q[3].err, 0);
        end

        // Steady state: one request per cycle never sees req_ready_o drop.
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b0, AW'(4 * (i % MEM_D)), 32'h0, a0, st);
            tot += st;
        end
        drain();
        check("steady_no_stall", tot, 0);

        for (int i = 0; i < 1500; i++) begin
            int k;
            logic rd;
            logic [AW-1:0] ad;
            k  = $urandom_range(0, 9);
            rd = 1'($urandom_range(0, 1));
            ad = AW'($urandom_range(0, MEM_D - 1) * 4);
            req_read_i  = rd;
            req_write_i = !rd;
            if (k == 0) ad = ad | AW'($urandom_range(1, 3));
            if (k == 1) ad = AW'($urandom_range(MEM_D, 200) * 4);
            if (k == 2) req_write_i = rd;
            req_addr_i  = ad;
            req_data_i  = $urandom;
            req_valid_i = ($urandom_range(0, 3) != 0);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drain();

        // Reset with responses pending drops them but keeps memory.
        rsp_ready_i = 1'b0;
        send(1'b1, 1'b0, 16'h0000, 32'h0, a0, st);
        send(1'b1, 1'b0, 16'h0004, 32'h0, a0, st);
        send(1'b1, 1'b0, 16'h0008, 32'h0, a0, st);
        repeat (LAT + 1) @(posedge clk);
        #1;
        check("pre_reset_valid", rsp_valid_o, 1);
        reset_n = 1'b0;
        #1;
        check("reset_valid_now", rsp_valid_o, 0);
        check("reset_data_now", rsp_data_o, 0);
        check("reset_ready_now", req_ready_o, 0);
        repeat (2) @(posedge clk);
        #1;
        log_q.delete();
        reset_n = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("release_ready", req_ready_o, 1);
        repeat (5) @(posedge clk);
        #1;
        check("no_stale", log_q.size(), 0);
        keep = mdl_mem[4];
        send(1'b1, 1'b0, 16'h0010, 32'h0, a0, st);
        drain();
        check("retain_count", log_q.size(), 1);
        if (log_q.size() == 1) check("retain_data", log_q[0].data, keep);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/w0rm_mem_responder.md
W0RM_MEM_RESPONDER -- requirements
Module: w0rm_mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of the request write data and the response read data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: width of the byte address.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 1024: number of DATA_WIDTH words, legal range 2 or more.
REQ-004 The block SHALL have parameter LATENCY, default 1: cycles from request accept to response visible, legal range 1..8.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4: response buffer entries and maximum outstanding requests, a power of 2 of at least 1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port req_valid_i, input, 1 bit: a request is present.
REQ-009 The block SHALL have port req_read_i, input, 1 bit: the request is a read.
REQ-010 The block SHALL have port req_write_i, input, 1 bit: the request is a write.
REQ-011 The block SHALL have port req_addr_i, input, ADDR_WIDTH bits: byte address.
REQ-012 The block SHALL have port req_data_i, input, DATA_WIDTH bits: write data.
REQ-013 The block SHALL have port req_ready_o, output, 1 bit: the block can accept a request.
REQ-014 The block SHALL have port rsp_valid_o, output, 1 bit: a response is at the buffer head.
REQ-015 The block SHALL have port rsp_ready_i, input, 1 bit: the consumer takes the head response.
REQ-016 The block SHALL have port rsp_data_o, output, DATA_WIDTH bits: read data, zero for writes and errors.
REQ-017 The block SHALL have port rsp_write_o, output, 1 bit: the response acknowledges a write.
REQ-018 The block SHALL have port rsp_error_o, output, 1 bit: the request was illegal.

Function
REQ-019 A request SHALL be accepted on a rising edge when req_valid_i and req_ready_o are both high.
REQ-020 Credit count SHALL equal in-flight pipeline entries plus buffer entries.
- req_ready_o SHALL be high iff credit count is less than FIFO_DEPTH and reset_n is high.
REQ-021 The credit count SHALL change as follows:
- increment on accept;
- decrement on pop, where pop = rsp_valid_o and rsp_ready_i;
- stay unchanged when accept and pop occur in the same cycle.
REQ-022 The word index SHALL be req_addr_i[ADDR_WIDTH-1:2].
- A request SHALL be an error if req_addr_i[1:0] is not 0, or the index is at least MEM_DEPTH, or req_read_i equals req_write_i.
REQ-023 A legal write SHALL update the array at its accept edge.
- An error write SHALL leave the array unchanged.
REQ-024 A legal read SHALL return the array contents at its accept edge, including any write accepted on an earlier edge.
REQ-025 A response accepted at edge k SHALL be visible on rsp_* from edge k+LATENCY when the buffer was otherwise empty.
- Otherwise it SHALL be visible when it reaches the buffer head.
- Responses SHALL be strictly in request order.
REQ-026 Every accepted request, including error requests, SHALL produce exactly one response.
- rsp_write_o SHALL equal the request's req_write_i.
- rsp_error_o SHALL be set per REQ-022.
- rsp_data_o SHALL be zero unless the request was a legal read.
REQ-027 Buffer read and write pointers SHALL wrap modulo FIFO_DEPTH.
- A pipeline push SHALL never find the buffer full; the credit rule guarantees this, and a push into a full buffer is a design error to be asserted.
REQ-028 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
- When the buffer is empty, a push SHALL not be visible until the following edge.
REQ-029 Requests SHALL be ignored while req_ready_o is low; no state SHALL change.
REQ-030 rsp_* outputs SHALL be held stable while rsp_valid_o is high and rsp_ready_i is low.

Reset
REQ-031 While reset_n is low, the block SHALL hold:
- pipeline valids, buffer pointers and credit count at 0;
- rsp_valid_o, rsp_write_o, rsp_error_o at 0 and rsp_data_o at all zeros;
- req_ready_o at 0.
REQ-032 Memory array contents SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and buffered responses.
- On the first edge after release, req_ready_o SHALL be 1.

Verification
REQ-034 Defaults: write 0xDEADBEEF to 0x10, then read 0x10 on the next cycle -> write ack at edge k+1 with rsp_write_o=1, rsp_error_o=0; read response one cycle later with data 0xDEADBEEF.
REQ-035 LATENCY=4, rsp_ready_i=1, back-to-back reads of 0x0, 0x4, 0x8 -> responses on three consecutive cycles starting 4 edges after the first accept, in order.
REQ-036 rsp_ready_i=0, issue 6 reads -> req_ready_o falls after 4 accepts, rsp_data_o held stable; raise rsp_ready_i -> all 6 responses in order, with credit count never above 4.
REQ-037 Misaligned read at 0x2, address 4*MEM_DEPTH, and read=write=1 -> three responses with rsp_error_o=1 and data 0; a later read shows the array unchanged.
REQ-038 Hold rsp_ready_i=1 with one accept per cycle at steady state -> req_ready_o stays high and pointers wrap past FIFO_DEPTH without loss.
REQ-039 Assert reset_n low with 3 responses pending -> rsp_valid_o=0 immediately; after release, req_ready_o=1, no stale responses, and memory data is retained.
